// File: rtl/runtime_cfg_pkg.sv
// Shared types and defaults for the runtime configuration controller.
//   state_e    : apply sequencer states
//   err_code_e : error codes reported on err_code_o
//   FIdx*      : field index map inside one thread's configuration bank
//   DefaultRst : packed per-field reset values (8 fields x 8 bits)
//   DefaultMax : packed per-field legal maximum (8 fields x 8 bits)
package runtime_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrBadIndex = 2'd1,
    ErrRange    = 2'd2,
    ErrTimeout  = 2'd3
  } err_code_e;

  // Field map; indices 5..7 are reserved and pinned to zero by their maximum.
  localparam int unsigned FIdxIssueW       = 0;
  localparam int unsigned FIdxMaxOutStores = 1;
  localparam int unsigned FIdxLdBufLimit   = 2;
  localparam int unsigned FIdxBpEn         = 3;
  localparam int unsigned FIdxFlushOnFence = 4;

  localparam logic [63:0] DefaultRst =
      (64'h04 << (8 * FIdxIssueW))       |
      (64'h08 << (8 * FIdxMaxOutStores)) |
      (64'h0C << (8 * FIdxLdBufLimit))   |
      (64'h01 << (8 * FIdxBpEn))         |
      (64'h00 << (8 * FIdxFlushOnFence));

  localparam logic [63:0] DefaultMax =
      (64'h04 << (8 * FIdxIssueW))       |
      (64'h10 << (8 * FIdxMaxOutStores)) |
      (64'h20 << (8 * FIdxLdBufLimit))   |
      (64'h01 << (8 * FIdxBpEn))         |
      (64'h01 << (8 * FIdxFlushOnFence));

endpackage

// File: rtl/runtime_cfg_bank.sv
// One thread's configuration storage: a staged bank written by software and
// an active bank consumed by the core, plus the per-field maximum check.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_req_i      : write request for this thread (field index already valid)
//   wr_field_i    : field index
//   wr_data_i     : value to stage
//   over_max_o    : wr_data_i exceeds the maximum of wr_field_i (combinational)
//   copy_i        : copy the whole staged bank into the active bank
//   active_o      : active bank, packed, field f at [f*FIELD_W +: FIELD_W]
module runtime_cfg_bank #(
  parameter int unsigned NUM_FIELDS = 8,
  parameter int unsigned FIELD_W    = 8,
  parameter int unsigned FIDX_W     = 3,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_RST = '0,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = '1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_req_i,
  input  logic [FIDX_W-1:0]             wr_field_i,
  input  logic [FIELD_W-1:0]            wr_data_i,
  output logic                          over_max_o,
  input  logic                          copy_i,
  output logic [NUM_FIELDS*FIELD_W-1:0] active_o
);

  localparam logic [NUM_FIELDS-1:0][FIELD_W-1:0] MaxArr = FIELD_MAX;

  logic [NUM_FIELDS-1:0][FIELD_W-1:0] staged_d, staged_q;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0] active_d, active_q;

  always_comb begin
    over_max_o = 1'b0;
    if (32'(wr_field_i) < NUM_FIELDS) begin
      over_max_o = (wr_data_i > MaxArr[wr_field_i]);
    end
  end

  // NOTE: every signal assigned in a combinational block gets its default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    staged_d = staged_q;
    active_d = active_q;
    if (wr_req_i && !over_max_o) begin
      staged_d[wr_field_i] = wr_data_i;
    end
    if (copy_i) begin
      active_d = staged_q;
    end
  end

  // NOTE: both banks are plain flops with architectural reset values, so
  // they are reset, unlike a RAM array whose contents would be left alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staged_q <= FIELD_RST;
      active_q <= FIELD_RST;
    end else begin
      staged_q <= staged_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/runtime_cfg_ctrl.sv
// Runtime per-thread configuration controller. Software writes land in a
// staged bank; an apply request flushes the target thread through a
// flush_req/flush_ack handshake and then copies staged to active in one edge.
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   wr_valid/ready, wr_thread/field/data : staged-field write port
//   apply_valid/ready, apply_thread      : apply request port
//   flush_req_o, flush_thread_o, flush_ack_i : pipeline flush handshake
//   active_cfg_o                 : all active banks, thread t at [t*NF*FW +: NF*FW]
//   cfg_update_o                 : one-cycle pulse on the updated thread's bit
//   busy_o                       : apply in progress
//   err_o, err_code_o            : one-cycle error pulse, code held until next error
module runtime_cfg_ctrl
  import runtime_cfg_pkg::*;
#(
  parameter int unsigned NUM_THREADS   = 2,
  parameter int unsigned NUM_FIELDS    = 8,
  parameter int unsigned FIELD_W       = 8,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_RST = DefaultRst,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = DefaultMax,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  localparam int unsigned TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int unsigned FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      wr_valid_i,
  output logic                                      wr_ready_o,
  input  logic [TID_W-1:0]                          wr_thread_i,
  input  logic [FIDX_W-1:0]                         wr_field_i,
  input  logic [FIELD_W-1:0]                        wr_data_i,
  input  logic                                      apply_valid_i,
  output logic                                      apply_ready_o,
  input  logic [TID_W-1:0]                          apply_thread_i,
  output logic                                      flush_req_o,
  output logic [TID_W-1:0]                          flush_thread_o,
  input  logic                                      flush_ack_i,
  output logic [NUM_THREADS*NUM_FIELDS*FIELD_W-1:0] active_cfg_o,
  output logic [NUM_THREADS-1:0]                    cfg_update_o,
  output logic                                      busy_o,
  output logic                                      err_o,
  output logic [1:0]                                err_code_o
);

  localparam int unsigned BankW   = NUM_FIELDS * FIELD_W;
  localparam int unsigned TmrW    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TmrW-1:0] TmrLast =
      TmrW'((FLUSH_TIMEOUT > 0) ? (FLUSH_TIMEOUT - 1) : 0);

  state_e           state_d, state_q;
  logic [TID_W-1:0] thread_d, thread_q;
  logic [TmrW-1:0]  timer_d, timer_q;
  logic             err_d, err_q;
  err_code_e        err_code_d, err_code_q;

  logic                   idle;
  logic                   wr_fire, apply_fire;
  logic                   wr_thread_ok, wr_field_ok, apply_thread_ok;
  logic                   wr_over_max;
  logic                   copy;
  logic [NUM_THREADS-1:0] bank_wr_req, bank_copy, bank_over_max;

  assign idle          = (state_q == StIdle);
  assign wr_ready_o    = idle;
  assign apply_ready_o = idle;
  assign wr_fire       = wr_valid_i && idle;
  assign apply_fire    = apply_valid_i && idle;

  assign wr_thread_ok    = (32'(wr_thread_i) < NUM_THREADS);
  assign wr_field_ok     = (32'(wr_field_i) < NUM_FIELDS);
  assign apply_thread_ok = (32'(apply_thread_i) < NUM_THREADS);

  // Route the write to its bank and pick that bank's range-check result.
  always_comb begin
    wr_over_max = 1'b0;
    bank_wr_req = '0;
    bank_copy   = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (wr_thread_i == TID_W'(t)) begin
        wr_over_max    = bank_over_max[t];
        bank_wr_req[t] = wr_fire && wr_field_ok;
      end
      bank_copy[t] = copy && (thread_q == TID_W'(t));
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_bank
    runtime_cfg_bank #(
      .NUM_FIELDS (NUM_FIELDS),
      .FIELD_W    (FIELD_W),
      .FIDX_W     (FIDX_W),
      .FIELD_RST  (FIELD_RST),
      .FIELD_MAX  (FIELD_MAX)
    ) u_bank (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_req_i   (bank_wr_req[t]),
      .wr_field_i (wr_field_i),
      .wr_data_i  (wr_data_i),
      .over_max_o (bank_over_max[t]),
      .copy_i     (bank_copy[t]),
      .active_o   (active_cfg_o[t*BankW +: BankW])
    );
  end

  // Apply sequencer, timer and error reporting.
  always_comb begin
    state_d    = state_q;
    thread_d   = thread_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    copy       = 1'b0;

    if (wr_fire) begin
      if (!wr_thread_ok || !wr_field_ok) begin
        err_d      = 1'b1;
        err_code_d = ErrBadIndex;
      end else if (wr_over_max) begin
        err_d      = 1'b1;
        err_code_d = ErrRange;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (apply_fire) begin
          if (apply_thread_ok) begin
            thread_d = apply_thread_i;
            timer_d  = '0;
            state_d  = StFlush;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrBadIndex;
          end
        end
      end
      StFlush: begin
        timer_d = timer_q + TmrW'(1);
        // Ack is checked first so an ack on the last timer cycle still applies.
        if (flush_ack_i) begin
          copy    = 1'b1;
          state_d = StDone;
        end else if ((FLUSH_TIMEOUT > 0) && (timer_q == TmrLast)) begin
          state_d    = StIdle;
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      thread_q   <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      thread_q   <= thread_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    cfg_update_o = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      cfg_update_o[t] = (state_q == StDone) && (thread_q == TID_W'(t));
    end
  end

  assign flush_req_o    = (state_q == StFlush);
  assign flush_thread_o = thread_q;
  assign busy_o         = !idle;
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;

endmodule

// File: tb/tb_runtime_cfg_ctrl.sv
// Directed bench for runtime_cfg_ctrl with three threads (so an out-of-range
// thread index is representable) and a 16-cycle flush timeout.
module tb_runtime_cfg_ctrl;

  localparam int NT  = 3;
  localparam int TO  = 16;
  localparam int TW  = 2;
  localparam int FIW = 3;
  localparam int BW  = 64;
  localparam logic [63:0] RST_V = 64'h0000_0000_010C_0804;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic              wr_valid_i = 1'b0;
  logic              wr_ready_o;
  logic [TW-1:0]     wr_thread_i = '0;
  logic [FIW-1:0]    wr_field_i = '0;
  logic [7:0]        wr_data_i = '0;
  logic              apply_valid_i = 1'b0;
  logic              apply_ready_o;
  logic [TW-1:0]     apply_thread_i = '0;
  logic              flush_req_o;
  logic [TW-1:0]     flush_thread_o;
  logic              flush_ack_i = 1'b0;
  logic [NT*BW-1:0]  active_cfg_o;
  logic [NT-1:0]     cfg_update_o;
  logic              busy_o;
  logic              err_o;
  logic [1:0]        err_code_o;

  int n_vec = 0;
  int n_err = 0;

  runtime_cfg_ctrl #(
    .NUM_THREADS   (NT),
    .FLUSH_TIMEOUT (TO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_thread_i    (wr_thread_i),
    .wr_field_i     (wr_field_i),
    .wr_data_i      (wr_data_i),
    .apply_valid_i  (apply_valid_i),
    .apply_ready_o  (apply_ready_o),
    .apply_thread_i (apply_thread_i),
    .flush_req_o    (flush_req_o),
    .flush_thread_o (flush_thread_o),
    .flush_ack_i    (flush_ack_i),
    .active_cfg_o   (active_cfg_o),
    .cfg_update_o   (cfg_update_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] act(input int t, input int f);
    return active_cfg_o[t*BW + f*8 +: 8];
  endfunction

  function automatic logic [63:0] bank(input int t);
    return active_cfg_o[t*BW +: BW];
  endfunction

  task automatic do_write(input int t, input int f, input logic [7:0] d);
    wr_valid_i  = 1'b1;
    wr_thread_i = TW'(t);
    wr_field_i  = FIW'(f);
    wr_data_i   = d;
    tick();
    wr_valid_i  = 1'b0;
  endtask

  task automatic do_apply(input int t);
    apply_valid_i  = 1'b1;
    apply_thread_i = TW'(t);
    tick();
    apply_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_ni = 1'b0;
    #2;
    n_vec++;
    if (active_cfg_o !== {NT{RST_V}}) begin
      n_err++;
      $display("FAIL reset_active got %h exp %h", active_cfg_o, {NT{RST_V}});
    end
    n_vec++;
    if ({flush_req_o, busy_o, err_o, err_code_o, cfg_update_o, flush_thread_o} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %b exp 0",
               {flush_req_o, busy_o, err_o, err_code_o, cfg_update_o, flush_thread_o});
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    n_vec++;
    if ({wr_ready_o, apply_ready_o, busy_o, flush_req_o} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_ready got %b exp 1100",
               {wr_ready_o, apply_ready_o, busy_o, flush_req_o});
    end
  endtask

  task automatic test_apply_ack();
    do_write(1, 2, 8'h10);
    n_vec++;
    if (err_o !== 1'b0 || act(1, 2) !== 8'h0C) begin
      n_err++;
      $display("FAIL write_staged_only err=%b act=%h exp err=0 act=0c", err_o, act(1, 2));
    end
    do_apply(1);
    n_vec++;
    if ({flush_req_o, flush_thread_o, busy_o, wr_ready_o, apply_ready_o} !== 6'b1_01_100) begin
      n_err++;
      $display("FAIL flush_entry got %b exp 101100",
               {flush_req_o, flush_thread_o, busy_o, wr_ready_o, apply_ready_o});
    end
    tick();
    tick();
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    n_vec++;
    if (act(1, 2) !== 8'h10 || cfg_update_o !== 3'b010 || flush_req_o !== 1'b0
        || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_cycle act=%h upd=%b req=%b busy=%b exp 10 010 0 1",
               act(1, 2), cfg_update_o, flush_req_o, busy_o);
    end
    n_vec++;
    if (bank(0) !== RST_V || bank(2) !== RST_V) begin
      n_err++;
      $display("FAIL other_threads t0=%h t2=%h exp %h", bank(0), bank(2), RST_V);
    end
    tick();
    n_vec++;
    if ({cfg_update_o, busy_o, wr_ready_o} !== 5'b000_01) begin
      n_err++;
      $display("FAIL after_done got %b exp 00001", {cfg_update_o, busy_o, wr_ready_o});
    end
  endtask

  task automatic test_errors();
    do_write(1, 2, 8'h21);
    n_vec++;
    if (err_o !== 1'b1 || err_code_o !== 2'd2) begin
      n_err++;
      $display("FAIL range_err err=%b code=%0d exp 1 2", err_o, err_code_o);
    end
    tick();
    n_vec++;
    if (err_o !== 1'b0 || err_code_o !== 2'd2) begin
      n_err++;
      $display("FAIL err_pulse_hold err=%b code=%0d exp 0 2", err_o, err_code_o);
    end
    do_write(3, 0, 8'h01);
    n_vec++;
    if (err_o !== 1'b1 || err_code_o !== 2'd1) begin
      n_err++;
      $display("FAIL bad_thread_wr err=%b code=%0d exp 1 1", err_o, err_code_o);
    end
    do_write(2, 2, 8'h20);
    n_vec++;
    if (err_o !== 1'b0 || err_code_o !== 2'd1) begin
      n_err++;
      $display("FAIL max_boundary err=%b code=%0d exp 0 1", err_o, err_code_o);
    end
    do_apply(3);
    n_vec++;
    if ({err_o, err_code_o, busy_o, flush_req_o} !== 5'b1_01_00) begin
      n_err++;
      $display("FAIL bad_thread_apply got %b exp 10100",
               {err_o, err_code_o, busy_o, flush_req_o});
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    int guard;
    do_write(1, 0, 8'h03);
    do_apply(1);
    cnt   = 0;
    guard = 0;
    while (flush_req_o === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      tick();
    end
    n_vec++;
    if (cnt !== TO) begin
      n_err++;
      $display("FAIL flush_req_len got %0d exp %0d", cnt, TO);
    end
    n_vec++;
    if ({err_o, err_code_o, busy_o} !== 4'b1_11_0 || act(1, 0) !== 8'h04) begin
      n_err++;
      $display("FAIL timeout_err got %b act=%h exp 1110 04",
               {err_o, err_code_o, busy_o}, act(1, 0));
    end
    tick();
    do_apply(1);
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    n_vec++;
    if (act(1, 0) !== 8'h03 || act(1, 2) !== 8'h10 || cfg_update_o !== 3'b010) begin
      n_err++;
      $display("FAIL retained_apply f0=%h f2=%h upd=%b exp 03 10 010",
               act(1, 0), act(1, 2), cfg_update_o);
    end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    do_apply(2);
    repeat (TO - 1) tick();
    n_vec++;
    if (flush_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL pre_timeout_req got %b exp 1", flush_req_o);
    end
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    n_vec++;
    if ({cfg_update_o, err_o, err_code_o} !== 6'b100_0_11 || act(2, 2) !== 8'h20) begin
      n_err++;
      $display("FAIL ack_wins got %b act=%h exp 100011 20",
               {cfg_update_o, err_o, err_code_o}, act(2, 2));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    wr_valid_i     = 1'b1;
    wr_thread_i    = 2'd0;
    wr_field_i     = 3'd0;
    wr_data_i      = 8'h02;
    apply_valid_i  = 1'b1;
    apply_thread_i = 2'd0;
    tick();
    wr_valid_i     = 1'b0;
    apply_valid_i  = 1'b0;
    n_vec++;
    if ({wr_ready_o, flush_req_o, flush_thread_o} !== 4'b0_1_00) begin
      n_err++;
      $display("FAIL same_cycle_flush got %b exp 0100",
               {wr_ready_o, flush_req_o, flush_thread_o});
    end
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    n_vec++;
    if (wr_ready_o !== 1'b0 || act(0, 0) !== 8'h02 || cfg_update_o !== 3'b001) begin
      n_err++;
      $display("FAIL same_cycle_apply rdy=%b act=%h upd=%b exp 0 02 001",
               wr_ready_o, act(0, 0), cfg_update_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    do_write(0, 1, 8'h05);
    do_apply(0);
    tick();
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if (flush_req_o !== 1'b0 || busy_o !== 1'b0 || active_cfg_o !== {NT{RST_V}}) begin
      n_err++;
      $display("FAIL async_reset req=%b busy=%b act=%h exp 0 0 %h",
               flush_req_o, busy_o, active_cfg_o, {NT{RST_V}});
    end
    tick();
    rst_ni = 1'b1;
    flush_ack_i = 1'b1;
    tick();
    tick();
    flush_ack_i = 1'b0;
    n_vec++;
    if (cfg_update_o !== 3'b000 || busy_o !== 1'b0 || active_cfg_o !== {NT{RST_V}}) begin
      n_err++;
      $display("FAIL late_ack upd=%b busy=%b act=%h exp 000 0 %h",
               cfg_update_o, busy_o, active_cfg_o, {NT{RST_V}});
    end
  endtask

  initial begin
    test_reset();
    test_apply_ack();
    test_errors();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/runtime_cfg_ctrl.md
Name: runtime_cfg_ctrl

Overview:
Runtime successor to the static elaboration-time configuration: holds per-thread tunable core settings (e.g. issue width, store/load-buffer limits, predictor enables) as staged and active register banks. Software-side writes land in the staged bank. An apply request flushes the target thread's pipeline through a req/ack handshake, then atomically copies staged to active. Sits between the CSR file and the frontend/issue/LSU, which consume active_cfg_o.

Parameters:
NUM_THREADS, 2, hardware threads; each has its own bank (≥1)
NUM_FIELDS, 8, configuration fields per thread (≥1)
FIELD_W, 8, bits per field
FIELD_RST, runtime_cfg_pkg::DefaultRst, NUM_FIELDS*FIELD_W packed reset values; field f at bits [f*FIELD_W +: FIELD_W]
FIELD_MAX, runtime_cfg_pkg::DefaultMax, NUM_FIELDS*FIELD_W packed legal maximum per field
FLUSH_TIMEOUT, 1024, cycles to wait for flush_ack_i; 0 = wait forever
Derived: TID_W = max(1,$clog2(NUM_THREADS)); FIDX_W = max(1,$clog2(NUM_FIELDS))

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wr_valid_i  in  1  staged-field write request
wr_ready_o  out  1  write accepted when valid&ready
wr_thread_i  in  TID_W  target thread
wr_field_i  in  FIDX_W  target field index
wr_data_i  in  FIELD_W  new value
apply_valid_i  in  1  apply request
apply_ready_o  out  1  apply accepted when valid&ready
apply_thread_i  in  TID_W  thread to apply
flush_req_o  out  1  pipeline flush request, level
flush_thread_o  out  TID_W  thread being flushed
flush_ack_i  in  1  pipeline drained for flush_thread_o
active_cfg_o  out  NUM_THREADS*NUM_FIELDS*FIELD_W  active configuration, registered
cfg_update_o  out  NUM_THREADS  one-cycle pulse per updated thread
busy_o  out  1  apply in progress
err_o  out  1  one-cycle error pulse
err_code_o  out  2  0 none, 1 bad index, 2 value>max, 3 flush timeout; held until next err_o

Behaviour:
- Reset (async, immediate): staged and active banks = FIELD_RST for every thread; FSM=IDLE; flush_req_o=0, flush_thread_o=0, cfg_update_o=0, busy_o=0, err_o=0, err_code_o=0, timer=0. Reset during FLUSH drops flush_req_o at once and discards the apply.
- FSM states: IDLE, FLUSH, DONE.
- wr_ready_o = apply_ready_o = (state==IDLE).
- Accepted write:
  - wr_thread_i≥NUM_THREADS or wr_field_i≥NUM_FIELDS -> no update; err_o pulses next cycle, code 1.
  - wr_data_i > FIELD_MAX[field] (unsigned) -> no update; err_o pulses, code 2.
  - Otherwise staged[thread][field] <= wr_data_i at that edge. Active bank is never touched by writes.
- Accepted apply:
  - apply_thread_i≥NUM_THREADS -> err code 1; stay in IDLE.
  - Otherwise latch the thread; next cycle state=FLUSH with flush_req_o=1, flush_thread_o=thread, busy_o=1, timer=0.
- Same-cycle write and apply in IDLE: both accepted; the write reaches staged first and is included in the apply.
- FLUSH: timer increments each cycle.
  - flush_ack_i=1 -> at that edge active[thread] <= staged[thread]; state=DONE.
  - Else, with FLUSH_TIMEOUT>0 and timer==FLUSH_TIMEOUT-1 -> state=IDLE, flush_req_o=0, err_o pulse code 3, active unchanged, staged retained.
  - Ack and timeout in the same cycle: ack wins.
- DONE (exactly 1 cycle): flush_req_o=0, cfg_update_o[thread]=1, busy_o=1, new active_cfg_o visible. Next state IDLE.
- Latency: apply accepted at cycle 0, ack at cycle 0+k (k≥1) -> new config and pulse at cycle k+1; ready again at k+2.
- flush_ack_i outside FLUSH is ignored. Only one apply is outstanding; other threads' active banks stay stable throughout.

Decomposition:
- runtime_cfg_pkg:
  - err_code_e and state_e enums.
  - Field index constants: FIdxIssueW=0, FIdxMaxOutStores=1, FIdxLdBufLimit=2, FIdxBpEn=3, FIdxFlushOnFence=4, 5-7 reserved.
  - DefaultRst and DefaultMax vectors.
- Sub-module runtime_cfg_bank: one thread's staged+active registers with write port, copy strobe and max-check. Instantiate NUM_THREADS times. The top level holds the FSM, timer and error logic.

Test Plan:
- Reset with defaults NUM_FIELDS=8, FIELD_W=8 -> active_cfg_o == FIELD_RST for both threads; all outputs 0.
- Write thread1 field2=0x10 (max 0x20), apply thread1, ack 3 cycles later -> active[1][2]=0x10 on cycle 4; cfg_update_o=2'b10 for one cycle; thread0 active unchanged.
- Write field2=0x21 (max 0x20) -> err_o pulse, err_code_o=2, staged unchanged; write thread=2 with NUM_THREADS=2 -> err_code_o=1.
- FLUSH_TIMEOUT=16, no ack -> flush_req_o high for exactly 16 cycles, then err_code_o=3, active unchanged; next apply with ack succeeds using the retained staged value.
- Same-cycle write field0=0x2 and apply thread0, then ack -> active[0][0]=0x2; wr_ready_o=0 during FLUSH/DONE.
- rst_ni low mid-FLUSH -> flush_req_o low immediately, active = FIELD_RST, and a late flush_ack_i after reset causes no update.
